// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   N_REQ / IDX_W : requester count and encoded index width
//   arb_state_e   : arbiter state (IDLE, GRANT)
//   rr_pick       : one-hot winner of a rotating-priority search starting at ptr
//   oh_idx        : index of a one-hot vector (0 for all-zero)
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } arb_state_e;

  // Search ptr, ptr+1, ... (mod N_REQ). Walking the offsets downwards lets the
  // lowest offset that is requesting overwrite any later candidate.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        rr_pick = N_REQ'(1) << idx;
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] oh_idx(input logic [N_REQ-1:0] oh);
    oh_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) begin
        oh_idx = oh_idx | IDX_W'(i);
      end
    end
  endfunction

endpackage

// File: rtl/Encoder4x2.sv
// One-hot to binary encoder, 4 inputs to 2-bit index.
//   onehot : one-hot (or all-zero) input vector
//   idx    : binary index of the set bit; 0 when no bit is set
module Encoder4x2 (
  input  logic [3:0] onehot,
  output logic [1:0] idx
);

  always_comb begin
    idx = 2'd0;
    case (onehot)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded grant hold.
// A requester keeps the grant while its req bit stays high, for at most
// MAX_HOLD consecutive cycles; on release the next requester in rotating
// order is granted on the same edge (no idle bubble).
// Optional feature macro: ARB_LOCK_EN adds the lock port, letting the current
// holder suspend the forced release while it keeps requesting.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   req       : request vector
//   lock      : hold extension from the current holder (ARB_LOCK_EN only)
//   gnt       : registered one-hot grant, zero when idle
//   gnt_idx   : encoded index of gnt, 0 when idle
//   gnt_valid : |gnt
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] pick;
  logic             holder_req;
  logic             at_limit;
  logic             lock_hold;
  logic             release_now;

  assign pick       = rr_pick(req, ptr_q);
  assign holder_req = |(req & gnt_q);
  assign at_limit   = (cnt_q == HoldLast);

`ifdef ARB_LOCK_EN
  assign lock_hold = lock & holder_req;
`else
  assign lock_hold = 1'b0;
`endif

  assign release_now = !holder_req || (at_limit && !lock_hold);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          cnt_d   = '0;
          ptr_d   = oh_idx(pick) + IDX_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // ptr already points past the holder, so a sole requester that was
          // forced off wraps back around to itself.
          if (|req) begin
            gnt_d = pick;
            cnt_d = '0;
            ptr_d = oh_idx(pick) + IDX_W'(1);
          end else begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (!at_limit) begin
          // At the limit only a lock can keep us here; the count saturates.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;

  Encoder4x2 u_enc (
    .onehot(gnt_q),
    .idx   (gnt_idx)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4. Several instances with different
// MAX_HOLD values share clock and reset; each has its own request vector.
module tb_rr_arbiter4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req1, req8, req4;
  logic [3:0] gnt1, gnt8, gnt4;
  logic [1:0] idx1, idx8, idx4;
  logic       vld1, vld8, vld4;
`ifdef ARB_LOCK_EN
  logic       lock;
  logic [3:0] req2, gnt2;
  logic [1:0] idx2;
  logic       vld2;
`endif

  rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1)
  );

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req8),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8)
  );

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req4),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4)
  );

`ifdef ARB_LOCK_EN
  rr_arbiter4 #(.MAX_HOLD(2), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .lock(lock),
    .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(vld2)
  );
`endif

  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input int sel, input logic [3:0] g,
                      input logic [1:0] i);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.gnt = g;
    e.idx = i;
    e.vld = (g != 4'b0000);
    sb.push_back(e);
  endtask

  task automatic observe(input int sel, output logic [3:0] g, output logic [1:0] i,
                         output logic v);
    g = 'x;
    i = 'x;
    v = 1'bx;
    case (sel)
      1: begin g = gnt1; i = idx1; v = vld1; end
      8: begin g = gnt8; i = idx8; v = vld8; end
      4: begin g = gnt4; i = idx4; v = vld4; end
`ifdef ARB_LOCK_EN
      2: begin g = gnt2; i = idx2; v = vld2; end
`endif
      default: ;
    endcase
  endtask

  // Advance one edge, then compare everything queued for this edge.
  task automatic tick();
    exp_t       e;
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      observe(e.sel, g, i, v);
      total++;
      assert (g === e.gnt) else begin
        bad++;
        $error("FAIL %s gnt: got %b want %b", e.tag, g, e.gnt);
      end
      total++;
      assert (i === e.idx) else begin
        bad++;
        $error("FAIL %s gnt_idx: got %0d want %0d", e.tag, i, e.idx);
      end
      total++;
      assert (v === e.vld) else begin
        bad++;
        $error("FAIL %s gnt_valid: got %b want %b", e.tag, v, e.vld);
      end
    end
  endtask

  task automatic step(input string tag, input int sel, input logic [3:0] g,
                      input logic [1:0] i);
    push(tag, sel, g, i);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req1  = 4'b1111;
    req8  = 4'b0000;
    req4  = 4'b0000;
`ifdef ARB_LOCK_EN
    req2  = 4'b0000;
    lock  = 1'b0;
`endif

    // Reset holds everything idle even with all requests up.
    repeat (3) begin
      push("rst_u1", 1, 4'b0000, 2'd0);
      push("rst_u8", 8, 4'b0000, 2'd0);
      tick();
    end
    rst_n = 1'b1;
    step("rst_release", 1, 4'b0001, 2'd0);

    // MAX_HOLD=1 with all requesting: one-cycle rotation.
    step("rot1", 1, 4'b0010, 2'd1);
    step("rot2", 1, 4'b0100, 2'd2);
    step("rot3", 1, 4'b1000, 2'd3);
    step("rot0", 1, 4'b0001, 2'd0);

    // MAX_HOLD=8, two requesters: 8 cycles each, no gap.
    req8 = 4'b0011;
    repeat (8) step("force_a", 8, 4'b0001, 2'd0);
    repeat (8) step("force_b", 8, 4'b0010, 2'd1);
    step("force_wrap", 8, 4'b0001, 2'd0);

    // Holder 0 drops; only req[3] remains.
    req8 = 4'b1000;
    step("nat_to3", 8, 4'b1000, 2'd3);
    // Non-holder arrivals do not preempt.
    req8 = 4'b1101;
    step("no_preempt", 8, 4'b1000, 2'd3);
    // Holder 3 drops; ptr wraps to 0.
    req8 = 4'b0101;
    step("nat_wrap", 8, 4'b0001, 2'd0);
    req8 = 4'b0000;
    step("to_idle", 8, 4'b0000, 2'd0);

    // Sole requester with MAX_HOLD=4 keeps the grant across forced releases.
    req4 = 4'b0100;
    repeat (12) step("sole", 4, 4'b0100, 2'd2);

`ifdef ARB_LOCK_EN
    req2 = 4'b0010;
    step("lk_grant", 2, 4'b0010, 2'd1);
    req2 = 4'b0011;
    lock = 1'b1;
    repeat (10) step("lk_hold", 2, 4'b0010, 2'd1);
    lock = 1'b0;
    step("lk_handover", 2, 4'b0001, 2'd0);
`endif

    // Reset mid-grant drops the grant on that edge.
    rst_n = 1'b0;
    push("rst_mid_u1", 1, 4'b0000, 2'd0);
    push("rst_mid_u4", 4, 4'b0000, 2'd0);
    tick();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
